write_pointer_full: RTL and testbench
=====================================

WRITE_POINTER_FULL -- requirements
Module: write_pointer_full

Interface
REQ-001 SHALL have parameter pwidth, default 4: pointer width, i.e. FIFO address width plus one wrap bit; DEPTH = 2^(pwidth-1).
REQ-002 SHALL have parameter af_thresh, default 1: almost_full asserts when free entries <= af_thresh; legal range 1..DEPTH-1.
REQ-003 SHALL have port w_clk, input, 1: write-domain clock; the only clock of the block.
REQ-004 SHALL have port w_rst, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port w_en, input, 1: write request from the write-domain client.
REQ-006 SHALL have port g_rptr, input, pwidth: Gray read pointer, asynchronous to w_clk, driven by the read-domain pointer block.
REQ-007 SHALL have port b_wptr, output reg, pwidth: binary write pointer; the low pwidth-1 bits are the FIFO memory write address.
REQ-008 SHALL have port g_wptr, output reg, pwidth: registered Gray write pointer, sent to the read domain.
REQ-009 SHALL have port full, output reg, 1: FIFO full.
REQ-010 SHALL have port almost_full, output reg, 1: free space <= af_thresh.
REQ-011 SHALL have port w_count, output reg, pwidth: occupancy as seen by the write domain, range 0..DEPTH.
REQ-012 SHALL have port overflow, output reg, 1: sticky flag for a write attempted while full.

Function
REQ-013 SHALL synchronise g_rptr into w_clk through a 2-flop chain (rq1, then rq2); no logic SHALL sit between the flops.
REQ-014 SHALL accept a write exactly when w_en=1 and full=0 on a rising w_clk edge; b_wptr_next = b_wptr + accept, modulo 2^pwidth.
REQ-015 SHALL update b_wptr to b_wptr_next and g_wptr to (b_wptr_next>>1)^b_wptr_next on every edge, so g_wptr is never stale relative to b_wptr.
REQ-016 SHALL register full = 1 when gray(b_wptr_next) equals rq2 with its two MSBs inverted and the remaining bits equal; otherwise full = 0.
REQ-017 SHALL compute rbin = Gray-to-binary(rq2) and register w_count = b_wptr_next - rbin, modulo 2^pwidth.
REQ-018 SHALL register almost_full = 1 when (DEPTH - w_count_next) <= af_thresh, where w_count_next is the value from REQ-017; almost_full SHALL be 1 whenever full is 1.
REQ-019 SHALL set overflow when w_en=1 and full=1 on an edge; overflow is cleared only by reset, and the rejected write SHALL NOT move b_wptr.
REQ-020 SHALL assert full at the same edge that accepts the DEPTH-th unread write (zero-cycle full latency).
REQ-021 SHALL deassert full, pessimistically, on the third w_clk edge after g_rptr changes (two sync flops plus the flag register); a write in that window is rejected.
REQ-022 SHALL wrap b_wptr from 2^pwidth-1 to 0 with full and w_count unaffected by the wrap itself.
REQ-023 SHALL treat an accepted write and a synchronised read pointer change on the same edge together, computing full and w_count from both new values.

Reset
REQ-024 SHALL, when w_rst=0, asynchronously clear b_wptr, g_wptr, rq1, rq2, w_count, full, almost_full and overflow to 0.
REQ-025 SHALL resume normal operation on the first rising edge of w_clk after w_rst returns high; reset asserted mid-burst SHALL discard all pointer state.

Structure
REQ-026 SHALL place the bin-to-Gray and Gray-to-binary functions and the DEPTH derivation in a shared FIFO package used by both pointer blocks.
REQ-027 SHALL implement the synchroniser as a sub-module sync_2ff (parameter width, clock, active-low async reset), reusable by the read side.

Verification (pwidth=4, DEPTH=8, af_thresh=1)
REQ-028 SHALL check: reset asserted -> all outputs 0, full=0, overflow=0.
REQ-029 SHALL check: g_rptr held at 0, 8 consecutive writes -> on the 8th edge full=1, b_wptr=4'b1000, g_wptr=4'b1100, w_count=8; almost_full=1 after the 7th write.
REQ-030 SHALL check: write while full -> b_wptr stays 4'b1000, overflow=1 and stays 1 through later non-full cycles.
REQ-031 SHALL check: from full, g_rptr goes to 4'b0001 -> full=0 and w_count=7 on the 3rd w_clk edge, not earlier.
REQ-032 SHALL check: 16 writes with the reader tracking -> b_wptr wraps 15->0, g_wptr goes 4'b1000->4'b0000, full never asserts.
REQ-033 SHALL check: w_rst pulsed low mid-burst, asynchronously to w_clk -> outputs clear immediately and the next write produces b_wptr=1, g_wptr=4'b0001.

Source files
------------

// File: rtl/write_pointer_full_pkg.sv
// Shared FIFO pointer helpers: Gray/binary conversion and depth derivation.
// Used by both the write-side and read-side pointer blocks.
// Functions work on a wide container; callers cast to their pointer width.
package write_pointer_full_pkg;

   localparam int PTR_MAX = 32;

   function automatic logic [PTR_MAX-1:0] bin2gray(input logic [PTR_MAX-1:0] b);
      return (b >> 1) ^ b;
   endfunction

   // Each binary bit is the XOR of its own and every higher Gray bit.
   function automatic logic [PTR_MAX-1:0] gray2bin(input logic [PTR_MAX-1:0] g);
      logic [PTR_MAX-1:0] b;
      b = g;
      for (int i = 1; i < PTR_MAX; i++) begin
         b = b ^ (g >> i);
      end
      return b;
   endfunction

   // One pointer bit is the wrap bit; the rest address the memory.
   function automatic int fifo_depth(input int pwidth);
      return 1 << (pwidth - 1);
   endfunction

endpackage

// File: rtl/write_pointer_full_sync_2ff.sv
// Two-flop synchroniser for a Gray-coded pointer crossing into clk.
// Latency: two clk edges; no backpressure.
// Purely registers between the flops so every bit resolves independently.
module sync_2ff #(
   parameter int width = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [width-1:0] d_i,
   output logic [width-1:0] q_o
);

   logic [width-1:0] rq1_q;
   logic [width-1:0] rq2_q;

   // Plain two-stage capture chain, cleared asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rq1_q <= '0;
         rq2_q <= '0;
      end else begin
         rq1_q <= d_i;
         rq2_q <= rq1_q;
      end
   end

   assign q_o = rq2_q;

endmodule

// File: rtl/write_pointer_full.sv
// Write-side FIFO pointer: binary/Gray write pointer, full, almost_full, occupancy, sticky overflow.
// Latency: full asserts on the accepting edge; deasserts 3 edges after the read pointer moves.
// Backpressure: writes are rejected while full (pointer holds, overflow is latched).
module write_pointer_full
   import write_pointer_full_pkg::*;
#(
   parameter int pwidth    = 4,
   parameter int af_thresh = 1
) (
   input  logic              w_clk,
   input  logic              w_rst,
   input  logic              w_en,
   input  logic [pwidth-1:0] g_rptr,
   output logic [pwidth-1:0] b_wptr,
   output logic [pwidth-1:0] g_wptr,
   output logic              full,
   output logic              almost_full,
   output logic [pwidth-1:0] w_count,
   output logic              overflow
);

   localparam int DEPTH = fifo_depth(pwidth);
   // Full pattern: Gray pointers differ only in their two MSBs.
   localparam logic [pwidth-1:0] FULL_MASK = pwidth'(3) << (pwidth - 2);

   logic [pwidth-1:0] rq2;
   logic [pwidth-1:0] b_wptr_q, b_wptr_d;
   logic [pwidth-1:0] g_wptr_q, g_wptr_d;
   logic [pwidth-1:0] w_count_q, w_count_d;
   logic              full_q, full_d;
   logic              af_q, af_d;
   logic              ovf_q, ovf_d;
   logic              accept;
   logic [pwidth-1:0] rbin;
   int                free_slots;

   sync_2ff #(.width(pwidth)) u_rptr_sync (
      .clk   (w_clk),
      .rst_n (w_rst),
      .d_i   (g_rptr),
      .q_o   (rq2)
   );

   // Next pointer, flags and occupancy, all derived from the same next pointer and synced read pointer.
   always_comb begin
      accept     = w_en & ~full_q;
      b_wptr_d   = b_wptr_q + pwidth'(accept);
      g_wptr_d   = pwidth'(bin2gray(PTR_MAX'(b_wptr_d)));
      rbin       = pwidth'(gray2bin(PTR_MAX'(rq2)));
      w_count_d  = b_wptr_d - rbin;
      full_d     = (g_wptr_d == (rq2 ^ FULL_MASK));
      free_slots = DEPTH - int'(w_count_d);
      af_d       = (free_slots <= af_thresh) | full_d;
      ovf_d      = ovf_q | (w_en & full_q);
   end

   // State registers; reset discards all pointer state immediately.
   always_ff @(posedge w_clk or negedge w_rst) begin
      if (!w_rst) begin
         b_wptr_q  <= '0;
         g_wptr_q  <= '0;
         w_count_q <= '0;
         full_q    <= 1'b0;
         af_q      <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         b_wptr_q  <= b_wptr_d;
         g_wptr_q  <= g_wptr_d;
         w_count_q <= w_count_d;
         full_q    <= full_d;
         af_q      <= af_d;
         ovf_q     <= ovf_d;
      end
   end

   assign b_wptr      = b_wptr_q;
   assign g_wptr      = g_wptr_q;
   assign w_count     = w_count_q;
   assign full        = full_q;
   assign almost_full = af_q;
   assign overflow    = ovf_q;

endmodule

// File: tb/tb_write_pointer_full.sv
// Directed bench for write_pointer_full (pwidth=4, DEPTH=8, af_thresh=1).
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
// Expected values are hand-computed constants and a Gray lookup table.
module tb_write_pointer_full;

   logic       w_clk;
   logic       w_rst;
   logic       w_en;
   logic [3:0] g_rptr;
   logic [3:0] b_wptr;
   logic [3:0] g_wptr;
   logic       full;
   logic       almost_full;
   logic [3:0] w_count;
   logic       overflow;

   int checks   = 0;
   int failures = 0;
   logic [3:0] gtab [16];

   write_pointer_full #(.pwidth(4), .af_thresh(1)) dut (
      .w_clk       (w_clk),
      .w_rst       (w_rst),
      .w_en        (w_en),
      .g_rptr      (g_rptr),
      .b_wptr      (b_wptr),
      .g_wptr      (g_wptr),
      .full        (full),
      .almost_full (almost_full),
      .w_count     (w_count),
      .overflow    (overflow)
   );

   initial begin
      w_clk = 1'b0;
      forever #5 w_clk = ~w_clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge w_clk);
      #1;
   endtask

   task automatic pulse_reset();
      #2 w_rst = 1'b0;
      g_rptr = 4'd0;
      #2 w_rst = 1'b1;
   endtask

   initial begin
      gtab = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
               4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
      w_rst  = 1'b1;
      w_en   = 1'b0;
      g_rptr = 4'd0;
      #1 w_rst = 1'b0;
      #2;
      // Reset state
      chk("rst_bwptr", 32'(b_wptr), 32'h0);
      chk("rst_gwptr", 32'(g_wptr), 32'h0);
      chk("rst_full", 32'(full), 32'h0);
      chk("rst_af", 32'(almost_full), 32'h0);
      chk("rst_count", 32'(w_count), 32'h0);
      chk("rst_ovf", 32'(overflow), 32'h0);
      #4 w_rst = 1'b1;

      // Fill to full with reader idle
      w_en = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         tick();
         if (i == 6) chk("af_before7", 32'(almost_full), 32'h0);
         if (i == 7) begin
            chk("af_after7", 32'(almost_full), 32'h1);
            chk("full_after7", 32'(full), 32'h0);
            chk("count_after7", 32'(w_count), 32'h7);
         end
      end
      chk("fill_full", 32'(full), 32'h1);
      chk("fill_bwptr", 32'(b_wptr), 32'h8);
      chk("fill_gwptr", 32'(g_wptr), 32'hC);
      chk("fill_count", 32'(w_count), 32'h8);
      chk("fill_af", 32'(almost_full), 32'h1);

      // Write while full is rejected and latched
      tick();
      chk("ovf_bwptr", 32'(b_wptr), 32'h8);
      chk("ovf_set", 32'(overflow), 32'h1);
      chk("ovf_full", 32'(full), 32'h1);
      w_en = 1'b0;

      // Reader consumes one entry; full clears on the third edge only
      g_rptr = 4'b0001;
      tick();
      chk("drain_e1_full", 32'(full), 32'h1);
      tick();
      chk("drain_e2_full", 32'(full), 32'h1);
      chk("drain_e2_count", 32'(w_count), 32'h8);
      tick();
      chk("drain_e3_full", 32'(full), 32'h0);
      chk("drain_e3_count", 32'(w_count), 32'h7);
      chk("drain_e3_af", 32'(almost_full), 32'h1);
      chk("ovf_sticky", 32'(overflow), 32'h1);

      // Wrap with the reader tracking every accepted write
      pulse_reset();
      chk("wrap_rst_ovf", 32'(overflow), 32'h0);
      w_en = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         tick();
         chk($sformatf("wrap_b%0d", i), 32'(b_wptr), 32'(i % 16));
         chk($sformatf("wrap_g%0d", i), 32'(g_wptr), 32'(gtab[i % 16]));
         chk($sformatf("wrap_full%0d", i), 32'(full), 32'h0);
         g_rptr = gtab[i % 16];
      end

      // Asynchronous reset mid-burst
      for (int i = 0; i < 3; i++) tick();
      chk("burst_b3", 32'(b_wptr), 32'h3);
      #2 w_rst = 1'b0;
      #1;
      chk("arst_bwptr", 32'(b_wptr), 32'h0);
      chk("arst_gwptr", 32'(g_wptr), 32'h0);
      chk("arst_count", 32'(w_count), 32'h0);
      chk("arst_full", 32'(full), 32'h0);
      chk("arst_af", 32'(almost_full), 32'h0);
      chk("arst_ovf", 32'(overflow), 32'h0);
      #1 w_rst = 1'b1;
      tick();
      chk("post_rst_bwptr", 32'(b_wptr), 32'h1);
      chk("post_rst_gwptr", 32'(g_wptr), 32'h1);
      chk("post_rst_count", 32'(w_count), 32'h1);
      w_en = 1'b0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
